// File: rtl/score_keeper_if.sv
// Bundles the game-control inputs and scoreboard outputs of score_keeper.
// The slave modport is the scorekeeper's view; master is the driver's view.
interface score_keeper_if;
  logic       start;
  logic       hit;
  logic       miss;
  logic [9:0] score;
  logic [9:0] high_score;
  logic [3:0] lives;
  logic       playing;
  logic       game_over;
  logic       new_high;

  modport slave (
    input  start,
    input  hit,
    input  miss,
    output score,
    output high_score,
    output lives,
    output playing,
    output game_over,
    output new_high
  );

  modport master (
    output start,
    output hit,
    output miss,
    input  score,
    input  high_score,
    input  lives,
    input  playing,
    input  game_over,
    input  new_high
  );
endinterface

// File: rtl/score_keeper.sv
// Game scorekeeper: edge-detects start/hit/miss, tracks score and lives through
// an IDLE/PLAY/OVER game loop and keeps the best final score since reset.
// Every output comes straight from a register.
module score_keeper #(
  parameter int unsigned MAX_SCORE = 99,
  parameter int unsigned LIVES     = 3
) (
  input  logic          clk,
  input  logic          rst,
  score_keeper_if.slave bus_io
);

  localparam logic [9:0] MaxScore  = 10'(MAX_SCORE);
  localparam logic [3:0] LivesInit = 4'(LIVES);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StOver = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       start_prev_q, hit_prev_q, miss_prev_q;
  logic [9:0] score_q, score_d;
  logic [9:0] high_q, high_d;
  logic [3:0] lives_q, lives_d;
  logic       new_high_q, new_high_d;
  logic       playing_q, playing_d;
  logic       game_over_q, game_over_d;

  logic       start_ev, hit_ev, miss_ev;
  logic [9:0] score_hit;

  // Rising-edge events; prev regs reset high so a level held through reset is not an event.
  always_comb begin
    start_ev = bus_io.start & ~start_prev_q;
    hit_ev   = bus_io.hit & ~hit_prev_q;
    miss_ev  = bus_io.miss & ~miss_prev_q;
  end

  // Score after this cycle's hit, saturating; applied before any same-cycle miss.
  always_comb begin
    score_hit = score_q;
    if (hit_ev && (score_q < MaxScore)) begin
      score_hit = score_q + 10'd1;
    end
  end

  // Next-state and next-output logic for the game FSM.
  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    high_d     = high_q;
    lives_d    = lives_q;
    new_high_d = new_high_q;

    case (state_q)
      StIdle, StOver: begin
        if (start_ev) begin
          state_d    = StPlay;
          score_d    = 10'd0;
          lives_d    = LivesInit;
          new_high_d = 1'b0;
        end
      end
      StPlay: begin
        score_d = score_hit;
        if (miss_ev) begin
          if (lives_q > 4'd1) begin
            lives_d = lives_q - 4'd1;
          end else begin
            lives_d = 4'd0;
            state_d = StOver;
            // Strictly greater: tying the record is not a new high.
            if (score_hit > high_q) begin
              high_d     = score_hit;
              new_high_d = 1'b1;
            end else begin
              new_high_d = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    playing_d   = (state_d == StPlay);
    game_over_d = (state_d == StOver);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      start_prev_q <= 1'b1;
      hit_prev_q   <= 1'b1;
      miss_prev_q  <= 1'b1;
      score_q      <= 10'd0;
      high_q       <= 10'd0;
      lives_q      <= LivesInit;
      new_high_q   <= 1'b0;
      playing_q    <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= bus_io.start;
      hit_prev_q   <= bus_io.hit;
      miss_prev_q  <= bus_io.miss;
      score_q      <= score_d;
      high_q       <= high_d;
      lives_q      <= lives_d;
      new_high_q   <= new_high_d;
      playing_q    <= playing_d;
      game_over_q  <= game_over_d;
    end
  end

  // Drive the interface outputs from registers only.
  always_comb begin
    bus_io.score      = score_q;
    bus_io.high_score = high_q;
    bus_io.lives      = lives_q;
    bus_io.playing    = playing_q;
    bus_io.game_over  = game_over_q;
    bus_io.new_high   = new_high_q;
  end

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: a behavioural game model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_score_keeper;

  localparam int unsigned MaxS   = 99;
  localparam int unsigned NLives = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  score_keeper_if bus ();

  score_keeper #(
    .MAX_SCORE(MaxS),
    .LIVES    (NLives)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  bit cmp_en  = 1'b0;

  // Model state: 0 idle, 1 playing, 2 game over.
  int m_state = 0;
  int m_score = 0;
  int m_high  = 0;
  int m_lives = NLives;
  int m_nh    = 0;
  int p_s     = 1;
  int p_h     = 1;
  int p_m     = 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game rules model.
  initial begin
    forever begin
      int se, he, me;
      @(posedge clk or posedge rst);
      if (rst) begin
        m_state = 0; m_score = 0; m_high = 0; m_lives = NLives; m_nh = 0;
        p_s = 1; p_h = 1; p_m = 1;
      end else begin
        se = (int'(bus.start) == 1 && p_s == 0) ? 1 : 0;
        he = (int'(bus.hit) == 1 && p_h == 0) ? 1 : 0;
        me = (int'(bus.miss) == 1 && p_m == 0) ? 1 : 0;
        p_s = int'(bus.start); p_h = int'(bus.hit); p_m = int'(bus.miss);
        if (m_state == 1) begin
          if (he == 1 && m_score < int'(MaxS)) m_score = m_score + 1;
          if (me == 1) begin
            if (m_lives > 1) begin
              m_lives = m_lives - 1;
            end else begin
              m_lives = 0;
              m_state = 2;
              if (m_score > m_high) begin
                m_high = m_score;
                m_nh   = 1;
              end else begin
                m_nh = 0;
              end
            end
          end
        end else if (se == 1) begin
          m_state = 1; m_score = 0; m_lives = NLives; m_nh = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("m_score", int'(bus.score), m_score);
        chk("m_high", int'(bus.high_score), m_high);
        chk("m_lives", int'(bus.lives), m_lives);
        chk("m_playing", int'(bus.playing), (m_state == 1) ? 1 : 0);
        chk("m_game_over", int'(bus.game_over), (m_state == 2) ? 1 : 0);
        chk("m_new_high", int'(bus.new_high), m_nh);
      end
    end
  end

  // Apply inputs, let one rising edge sample them, then settle just after it.
  task automatic tick(input bit s, input bit h, input bit m);
    bus.start = s;
    bus.hit   = h;
    bus.miss  = m;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_hit();
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_miss();
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.hit   = 1'b0;
    bus.miss  = 1'b0;
    rst       = 1'b1;
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    cmp_en = 1'b1;
    rst    = 1'b0;

    // Reset state
    chk("rst_score", int'(bus.score), 0);
    chk("rst_high", int'(bus.high_score), 0);
    chk("rst_lives", int'(bus.lives), 3);
    chk("rst_playing", int'(bus.playing), 0);
    chk("rst_over", int'(bus.game_over), 0);
    chk("rst_new_high", int'(bus.new_high), 0);

    // Game 1: start, five hits with one-cycle latency each
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("g1_playing", int'(bus.playing), 1);
    chk("g1_score0", int'(bus.score), 0);
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      chk("hit_latency", int'(bus.score), i);
      tick(1'b0, 1'b0, 1'b0);
    end
    chk("g1_lives", int'(bus.lives), 3);

    // Start during play is ignored
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("start_in_play", int'(bus.score), 5);

    // Held hit counts once
    repeat (10) tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("held_hit", int'(bus.score), 6);

    pulse_hit();
    pulse_miss();
    pulse_miss();
    chk("g1_lives1", int'(bus.lives), 1);
    chk("g1_still_play", int'(bus.playing), 1);

    // Simultaneous hit and final miss: the point counts
    tick(1'b0, 1'b1, 1'b1);
    chk("hm_score", int'(bus.score), 8);
    chk("hm_lives", int'(bus.lives), 0);
    chk("hm_over", int'(bus.game_over), 1);
    chk("hm_playing", int'(bus.playing), 0);
    chk("hm_high", int'(bus.high_score), 8);
    chk("hm_new_high", int'(bus.new_high), 1);

    // Hits ignored in OVER
    tick(1'b0, 1'b0, 1'b0);
    pulse_hit();
    chk("over_hold", int'(bus.score), 8);

    // Game 2: equal score is not a new high
    tick(1'b1, 1'b0, 1'b0);
    chk("g2_score0", int'(bus.score), 0);
    chk("g2_lives", int'(bus.lives), 3);
    chk("g2_nh_clr", int'(bus.new_high), 0);
    chk("g2_high_kept", int'(bus.high_score), 8);
    tick(1'b0, 1'b0, 1'b0);
    repeat (8) pulse_hit();
    repeat (3) pulse_miss();
    chk("g2_over", int'(bus.game_over), 1);
    chk("g2_score", int'(bus.score), 8);
    chk("g2_high", int'(bus.high_score), 8);
    chk("g2_new_high", int'(bus.new_high), 0);

    // Game 3: saturation at MAX_SCORE
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("g3_score0", int'(bus.score), 0);
    chk("g3_high", int'(bus.high_score), 8);
    repeat (98) pulse_hit();
    chk("sat_98", int'(bus.score), 98);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      chk("sat_99", int'(bus.score), 99);
      tick(1'b0, 1'b0, 1'b0);
    end
    repeat (3) pulse_miss();
    chk("g3_high", int'(bus.high_score), 99);
    chk("g3_new_high", int'(bus.new_high), 1);

    // Game 4: asynchronous reset mid-game
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    repeat (4) pulse_hit();
    chk("g4_score", int'(bus.score), 4);
    bus.start = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    chk("async_score", int'(bus.score), 0);
    chk("async_high", int'(bus.high_score), 0);
    chk("async_playing", int'(bus.playing), 0);
    chk("async_lives", int'(bus.lives), 3);
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    rst = 1'b0;

    // Start held through reset release stays idle
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("held_start_idle", int'(bus.playing), 0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("restart_play", int'(bus.playing), 1);
    chk("restart_score", int'(bus.score), 0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
